ripple_carry_counter: RTL and testbench

- WIDTH-bit free-running binary down-counter built as a chain of toggle stages with a rippled borrow.
- Default width is 4.
- Used as a simple cycle/timebase counter. The count decrements once per rising clock edge and wraps from 0 to all-ones.
- Synchronous clear to zero.

---
 rtl/ripple_carry_counter.sv | 85 ++++++++
 tb/tb_ripple_carry_counter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ripple_carry_counter.sv
// ---------------------------------------------------------------------------
// ripple_carry_counter
//
// Free-running WIDTH-bit binary down-counter built from a chain of toggle
// stages. Stage 0 toggles every cycle; stage i toggles only when all lower
// bits are zero. That condition is the borrow, and it ripples
// combinationally from the LSB upward. Every stage flop shares clk, so the
// design is fully synchronous and has no derived clocks.
//
// Reset is synchronous and active-high, and it takes priority over counting.
// The count wraps from 0 to all-ones with no stall.
//
// The output q is always valid. There is no handshake, so a new value is
// presented after every rising edge of clk.
//
// Parameters:
//   WIDTH       counter width in bits, legal range 1..32 (default 4)
//
// Ports:
//   clk         input   single clock; all state updates on the rising edge
//   reset       input   synchronous active-high clear to zero
//   q           output  [WIDTH-1:0] current count, driven from stage flops
//   borrow_out  output  present only with RIPPLE_CARRY_COUNTER_BORROW_OUT_EN;
//                       registered one-cycle pulse in the cycle where q has
//                       just wrapped from 0 to all-ones
//
// Optional feature macro: RIPPLE_CARRY_COUNTER_BORROW_OUT_EN
// ---------------------------------------------------------------------------
module ripple_carry_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
`ifdef RIPPLE_CARRY_COUNTER_BORROW_OUT_EN
    ,
    output logic             borrow_out
`endif
);

    // borrow[i] is high when every bit below stage i is zero, so stage i
    // must toggle on the next edge. Stage 0 has no lower bits and therefore
    // always toggles.
    logic [WIDTH-1:0] borrow;

    always_comb begin
        borrow    = '0;
        borrow[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            borrow[i] = borrow[i-1] & ~q[i-1];
        end
    end

    // Toggle-stage chain. Because each bit flips only when its borrow is
    // set, the chain as a whole computes q - 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (borrow[i]) begin
                    q[i] <= ~q[i];
                end
            end
        end
    end

`ifdef RIPPLE_CARRY_COUNTER_BORROW_OUT_EN
    // A borrow that passes the top stage means the count is currently zero,
    // so the next edge wraps it to all-ones. Registering this condition
    // lines the pulse up with the all-ones value of q.
    logic wrap;

    assign wrap = borrow[WIDTH-1] & ~q[WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            borrow_out <= 1'b0;
        end else begin
            borrow_out <= wrap;
        end
    end
`endif

endmodule

// File: tb/tb_ripple_carry_counter.sv
// ---------------------------------------------------------------------------
// tb_ripple_carry_counter
//
// Two counter instances (WIDTH=4 and WIDTH=3) share one clock and one reset.
// The driver applies reset on the falling edge. After each rising edge it
// works out the expected count with plain modular arithmetic and pushes it
// into a per-instance queue. A monitor running on the falling edge pops
// each queue and compares the value against the DUT.
// ---------------------------------------------------------------------------
module tb_ripple_carry_counter;

    localparam int W4 = 4;
    localparam int W3 = 3;

    logic          clk;
    logic          reset;
    logic [W4-1:0] q4;
    logic [W3-1:0] q3;
    logic          bo4;
    logic          bo3;

    // Expected entries hold {borrow_out, q}.
    logic [W4:0] exp_q4[$];
    logic [W3:0] exp_q3[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state. The value -1 means "not yet reset".
    int model4 = -1;
    int model3 = -1;

`ifdef RIPPLE_CARRY_COUNTER_BORROW_OUT_EN
    ripple_carry_counter #(.WIDTH(W4)) dut4 (
        .clk(clk), .reset(reset), .q(q4), .borrow_out(bo4)
    );
    ripple_carry_counter #(.WIDTH(W3)) dut3 (
        .clk(clk), .reset(reset), .q(q3), .borrow_out(bo3)
    );
`else
    ripple_carry_counter #(.WIDTH(W4)) dut4 (
        .clk(clk), .reset(reset), .q(q4)
    );
    ripple_carry_counter #(.WIDTH(W3)) dut3 (
        .clk(clk), .reset(reset), .q(q3)
    );
    assign bo4 = 1'b0;
    assign bo3 = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver ----------------
    // Runs one cycle: reset is applied on the falling edge, then the
    // expectation for the following rising edge is queued.
    task automatic step(input logic rst);
        int  mod4;
        int  mod3;
        logic wrap4;
        logic wrap3;
        mod4 = 1 << W4;
        mod3 = 1 << W3;
        @(negedge clk);
        reset = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            model4 = 0;
            model3 = 0;
            wrap4  = 1'b0;
            wrap3  = 1'b0;
        end else begin
            wrap4  = (model4 == 0);
            wrap3  = (model3 == 0);
            model4 = (model4 + mod4 - 1) % mod4;
            model3 = (model3 + mod3 - 1) % mod3;
        end
        if (model4 >= 0) begin
            exp_q4.push_back({wrap4, model4[W4-1:0]});
            exp_q3.push_back({wrap3, model3[W3-1:0]});
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        logic [W4:0] e4;
        logic [W3:0] e3;
        if (exp_q4.size() > 0) begin
            e4 = exp_q4.pop_front();
            n_checks++;
            if (q4 !== e4[W4-1:0]) begin
                n_fail++;
                $display("FAIL q_w4 at %0t: got %h expected %h", $time, q4, e4[W4-1:0]);
            end
`ifdef RIPPLE_CARRY_COUNTER_BORROW_OUT_EN
            n_checks++;
            if (bo4 !== e4[W4]) begin
                n_fail++;
                $display("FAIL borrow_w4 at %0t: got %b expected %b", $time, bo4, e4[W4]);
            end
`endif
        end
        if (exp_q3.size() > 0) begin
            e3 = exp_q3.pop_front();
            n_checks++;
            if (q3 !== e3[W3-1:0]) begin
                n_fail++;
                $display("FAIL q_w3 at %0t: got %h expected %h", $time, q3, e3[W3-1:0]);
            end
`ifdef RIPPLE_CARRY_COUNTER_BORROW_OUT_EN
            n_checks++;
            if (bo3 !== e3[W3]) begin
                n_fail++;
                $display("FAIL borrow_w3 at %0t: got %b expected %b", $time, bo3, e3[W3]);
            end
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int waited;
        reset = 1'b1;

        // Reset clear: two edges with reset held.
        step(1'b1);
        step(1'b1);

        // Full down-count, the wrap edge, then one more full period.
        run(33);

        // Mid-count reset: count down from zero to 1010 (six edges).
        step(1'b1);
        run(6);
        step(1'b1);
        run(3);

        // Reset held for five edges while counting would otherwise run.
        for (int i = 0; i < 5; i++) step(1'b1);
        run(2);

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 15) == 0);
        end
        run(20);

        // Drain the scoreboard within a bounded number of cycles.
        waited = 0;
        while ((exp_q4.size() > 0 || exp_q3.size() > 0) && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q4.size() != 0 || exp_q3.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d entries left, expected 0",
                     exp_q4.size(), exp_q3.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
